// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the multiplexed display scan path.
//   - scan_state_t : scan sequencer state encoding (IDLE, SHOW, BLANK_GAP)
//   - NUM_DIGITS   : number of display digits walked by the scanner
//   - SEL_W        : width of the digit select bus feeding the 2-to-4 decoder
//   - lowest_set() : index of the lowest set bit of a digit mask
// ---------------------------------------------------------------------------
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW      = 2'd1,
    BLANK_GAP = 2'd2
  } scan_state_t;

  // Scans from the top down so the last hit is the lowest set bit.
  // Returns 0 for an empty mask; callers guard against that case.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/next_digit_sel.sv
// ---------------------------------------------------------------------------
// next_digit_sel
// Purely combinational search for the next enabled digit.
// Ports:
//   i_cur   [SEL_W-1:0]      currently selected digit
//   i_mask  [NUM_DIGITS-1:0] digit participation mask (bit i = digit i on)
//   o_next  [SEL_W-1:0]      next set mask bit searching upward from
//                            i_cur+1, wrapping 3->0, with i_cur tried last
//   o_wrap                   next digit index is <= current (frame wrap)
//   o_none                   mask is empty; o_next is meaningless
// ---------------------------------------------------------------------------
module next_digit_sel
  import disp_pkg::*;
(
  input  logic [SEL_W-1:0]      i_cur,
  input  logic [NUM_DIGITS-1:0] i_mask,
  output logic [SEL_W-1:0]      o_next,
  output logic                  o_wrap,
  output logic                  o_none
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Offsets 1..NUM_DIGITS; the final offset wraps back onto i_cur itself,
  // so a single enabled digit selects itself again.
  always_comb begin
    o_next  = i_cur;
    w_found = 1'b0;
    w_idx   = i_cur;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      w_idx = i_cur + SEL_W'(k);
      if (!w_found && i_mask[w_idx]) begin
        o_next  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_none = ~|i_mask;
  assign o_wrap = w_found && (o_next <= i_cur);

endmodule

// File: rtl/digit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// digit_scan_ctrl
// Scan sequencer in front of the 2-to-4 digit decoder. Each enabled digit is
// shown for DIV cycles, then the decoder is blanked for BLANK cycles to
// avoid ghosting, then the next enabled digit is selected.
// Parameters:
//   DIV   SHOW dwell per digit in clock cycles (>= 1)
//   BLANK blanking gap in clock cycles (>= 0, 0 = back-to-back digits)
//   CW    dwell/blank counter width; DIV and BLANK must fit
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_en          scan enable; low forces IDLE
//   i_digit_mask  bit i = 1 means digit i participates
//   o_a           registered digit select to the decoder
//   o_dec_en      registered decoder enable
//   o_frame       one-cycle pulse when the scan wraps to a lower/equal digit
// ---------------------------------------------------------------------------
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int BLANK = 1,
  parameter int CW    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NUM_DIGITS-1:0] i_digit_mask,
  output logic [SEL_W-1:0]      o_a,
  output logic                  o_dec_en,
  output logic                  o_frame
);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam bit            HAS_BLANK  = (BLANK > 0);

  scan_state_t      r_state;
  logic [SEL_W-1:0] r_a;
  logic             r_dec_en;
  logic             r_frame;
  logic [CW-1:0]    r_cnt;

  logic [SEL_W-1:0] w_next;
  logic             w_wrap;
  logic             w_none;

  next_digit_sel u_next_digit_sel (
    .i_cur  (r_a),
    .i_mask (i_digit_mask),
    .o_next (w_next),
    .o_wrap (w_wrap),
    .o_none (w_none)
  );

  // Sequencer. DEC_EN is registered alongside the state so it is high
  // exactly while in SHOW. The mask only matters at IDLE exit and at an
  // advance, since that is the only time w_next/w_none are consumed.
  // A is only updated when DEC_EN goes (or stays) high for a new digit,
  // never mid-dwell.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_dec_en <= 1'b0;
      r_frame  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_frame <= 1'b0;
      if (!i_en) begin
        r_state  <= IDLE;
        r_dec_en <= 1'b0;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_dec_en <= 1'b0;
            r_cnt    <= '0;
            if (!w_none) begin
              r_a      <= lowest_set(i_digit_mask);
              r_state  <= SHOW;
              r_dec_en <= 1'b1;
            end
          end

          SHOW: begin
            if (r_cnt == DIV_LAST) begin
              r_cnt <= '0;
              if (HAS_BLANK) begin
                r_state  <= BLANK_GAP;
                r_dec_en <= 1'b0;
              end else if (w_none) begin
                r_state  <= IDLE;
                r_dec_en <= 1'b0;
              end else begin
                r_a     <= w_next;
                r_frame <= w_wrap;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end

          BLANK_GAP: begin
            if (r_cnt == BLANK_LAST) begin
              r_cnt <= '0;
              if (w_none) begin
                r_state  <= IDLE;
                r_dec_en <= 1'b0;
              end else begin
                r_state  <= SHOW;
                r_dec_en <= 1'b1;
                r_a      <= w_next;
                r_frame  <= w_wrap;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end

          default: begin
            r_state  <= IDLE;
            r_dec_en <= 1'b0;
            r_cnt    <= '0;
          end
        endcase
      end
    end
  end

  assign o_a      = r_a;
  assign o_dec_en = r_dec_en;
  assign o_frame  = r_frame;

endmodule
